// File: rtl/pcie_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pcie_rst_sequencer
// Description : Reset sequencer for the PCIe hard-IP wrapper. It merges
//               power-on, link-exit, LTSSM Disabled and software reset
//               requests into one prioritised state machine. The IP core
//               resets are released first and the application reset last.
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_rst_sequencer #(
    parameter int HOLD_CYCLES     = 1024,
    parameter int SIM_HOLD_CYCLES = 32,
    parameter int APP_DELAY       = 16,     // must be >= 2
    parameter int LINK_TIMEOUT    = 65535,
    parameter int CNT_W           = 16
) (
    input  logic       pld_clk_i,
    input  logic       npor_i,
    input  logic       test_sim_i,
    input  logic       dlup_exit_i,
    input  logic       hotrst_exit_i,
    input  logic       l2_exit_i,
    input  logic [4:0] ltssm_i,
    input  logic       sw_rst_req_i,
    output logic       sw_rst_ack_o,
    output logic       srst_o,
    output logic       crst_o,
    output logic       app_rstn_o,
    output logic [2:0] seq_state_o,
    output logic [7:0] rst_count_o,
    output logic       link_timeout_o
);

    localparam logic [4:0] C_LTSSM_L0       = 5'h0F;
    localparam logic [4:0] C_LTSSM_DISABLED = 5'h10;

    localparam logic [CNT_W-1:0] C_HOLD_LAST     = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_SIM_HOLD_LAST = CNT_W'(SIM_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST  = CNT_W'(LINK_TIMEOUT - 1);
    // The WAIT_LINK cycle that observes L0 is the first cycle of the
    // application delay, so APP_DLY itself lasts APP_DELAY-1 cycles.
    localparam logic [CNT_W-1:0] C_APP_LAST      = CNT_W'(APP_DELAY - 2);
    localparam logic [CNT_W-1:0] C_CNT_ONE       = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_ASSERT    = 3'd0,
        ST_HOLD      = 3'd1,
        ST_WAIT_LINK = 3'd2,
        ST_APP_DLY   = 3'd3,
        ST_RUN       = 3'd4
    } state_e;

    logic [1:0]       sync_q;
    logic             rstn_s;
    logic             dlup_q, hotrst_q, l2_q;
    logic [4:0]       ltssm_q;
    logic             evt_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       rst_count_q, rst_count_d;
    logic             timeout_q, timeout_d;
    logic             ack_q, ack_d;
    logic             srst_q, srst_d;
    logic             crst_q, crst_d;
    logic             app_rstn_q, app_rstn_d;
    logic [CNT_W-1:0] hold_last;

    // Power-on reset synchronizer: asynchronous assert, synchronous release.
    always_ff @(posedge pld_clk_i or negedge npor_i) begin
        if (!npor_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign rstn_s    = sync_q[1];
    assign hold_last = test_sim_i ? C_SIM_HOLD_LAST : C_HOLD_LAST;

    // Register the hard-IP status inputs, then fold them into one event flag.
    always_ff @(posedge pld_clk_i or negedge rstn_s) begin
        if (!rstn_s) begin
            dlup_q   <= 1'b1;
            hotrst_q <= 1'b1;
            l2_q     <= 1'b1;
            ltssm_q  <= 5'h00;
            evt_q    <= 1'b0;
        end else begin
            dlup_q   <= dlup_exit_i;
            hotrst_q <= hotrst_exit_i;
            l2_q     <= l2_exit_i;
            ltssm_q  <= ltssm_i;
            evt_q    <= ~dlup_q | ~hotrst_q | ~l2_q | (ltssm_q == C_LTSSM_DISABLED);
        end
    end

    // Next-state, counter, telemetry and output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timeout_d   = timeout_q;
        ack_d       = 1'b0;
        rst_count_d = rst_count_q;

        case (state_q)
            ST_ASSERT: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (cnt_q == hold_last) begin
                    state_d = ST_WAIT_LINK;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            ST_WAIT_LINK: begin
                if (ltssm_q == C_LTSSM_L0) begin
                    state_d = ST_APP_DLY;
                end else if (cnt_q == C_TIMEOUT_LAST) begin
                    state_d   = ST_ASSERT;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            ST_APP_DLY: begin
                if (cnt_q == C_APP_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            ST_RUN: begin
                // A request raised earlier is still held high, so it is
                // picked up here on the first RUN cycle.
                if (sw_rst_req_i) begin
                    state_d = ST_ASSERT;
                    ack_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_ASSERT;
            end
        endcase

        // A link event overrides everything; a coincident timeout is not
        // recorded since the reset was caused by the event.
        if (evt_q) begin
            state_d   = ST_ASSERT;
            timeout_d = timeout_q;
        end

        if ((state_d != state_q) || (state_d == ST_ASSERT)) begin
            cnt_d = '0;
        end

        if ((state_d == ST_ASSERT) && (rst_count_q != 8'hFF)) begin
            rst_count_d = rst_count_q + 8'd1;
        end

        srst_d     = (state_d == ST_ASSERT) || (state_d == ST_HOLD);
        crst_d     = (state_d == ST_ASSERT) || (state_d == ST_HOLD);
        app_rstn_d = (state_d == ST_RUN);
    end

    // State register and registered outputs.
    always_ff @(posedge pld_clk_i or negedge rstn_s) begin
        if (!rstn_s) begin
            state_q     <= ST_ASSERT;
            cnt_q       <= '0;
            rst_count_q <= 8'h00;
            timeout_q   <= 1'b0;
            ack_q       <= 1'b0;
            srst_q      <= 1'b1;
            crst_q      <= 1'b1;
            app_rstn_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rst_count_q <= rst_count_d;
            timeout_q   <= timeout_d;
            ack_q       <= ack_d;
            srst_q      <= srst_d;
            crst_q      <= crst_d;
            app_rstn_q  <= app_rstn_d;
        end
    end

    assign sw_rst_ack_o   = ack_q;
    assign srst_o         = srst_q;
    assign crst_o         = crst_q;
    assign app_rstn_o     = app_rstn_q;
    assign seq_state_o    = state_q;
    assign rst_count_o    = rst_count_q;
    assign link_timeout_o = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_pcie_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcie_rst_sequencer
// Description : Self-checking bench for pcie_rst_sequencer. A phase/duration
//               model of the sequencer is checked against the DUT every
//               cycle, plus directed scenarios with hand-computed edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcie_rst_sequencer;

    localparam int C_SIM_HOLD  = 32;
    localparam int C_APP_DELAY = 16;
    localparam int C_LT        = 64;

    logic       clk = 1'b0;
    logic       npor, test_sim, dlup, hotrst, l2, req;
    logic [4:0] ltssm;
    logic       ack, srst, crst, app_rstn, link_to;
    logic [2:0] seq_state;
    logic [7:0] rst_count;

    int checks = 0;
    int errors = 0;
    int ecnt;                  // edges since npor release
    logic       rec_ev [8];
    logic [4:0] rec_lt [8];
    logic       rec_req[8];

    // model
    int m_state, m_since, m_cnt, m_to, m_ack;
    // observation helpers
    int ack_flag = 0, ack_edge = 0, ack_total = 0, run_entry = 0, prev_seq = 0;

    always #5 clk = ~clk;

    pcie_rst_sequencer #(
        .HOLD_CYCLES    (1024),
        .SIM_HOLD_CYCLES(C_SIM_HOLD),
        .APP_DELAY      (C_APP_DELAY),
        .LINK_TIMEOUT   (C_LT),
        .CNT_W          (16)
    ) dut (
        .pld_clk_i     (clk),
        .npor_i        (npor),
        .test_sim_i    (test_sim),
        .dlup_exit_i   (dlup),
        .hotrst_exit_i (hotrst),
        .l2_exit_i     (l2),
        .ltssm_i       (ltssm),
        .sw_rst_req_i  (req),
        .sw_rst_ack_o  (ack),
        .srst_o        (srst),
        .crst_o        (crst),
        .app_rstn_o    (app_rstn),
        .seq_state_o   (seq_state),
        .rst_count_o   (rst_count),
        .link_timeout_o(link_to)
    );

    always @(posedge clk or negedge npor) begin
        if (!npor) ecnt <= 0;
        else       ecnt <= ecnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    // Record what the DUT samples on each edge (edge number = ecnt+1 here).
    initial forever begin
        @(posedge clk);
        rec_ev [(ecnt + 1) % 8] = !dlup || !hotrst || !l2 || (ltssm == 5'h10);
        rec_lt [(ecnt + 1) % 8] = ltssm;
        rec_req[(ecnt + 1) % 8] = req;
    end

    // Behavioural model: each phase is a duration measured from its entry edge.
    task automatic model_step(input int e);
        int evp, nxt, tmo, age;
        logic [4:0] ltp;
        evp = (e - 2 >= 3) ? int'(rec_ev[(e - 2) % 8]) : 0;
        ltp = (e - 1 >= 3) ? rec_lt[(e - 1) % 8] : 5'h00;
        age = e - m_since;
        nxt = m_state;
        tmo = 0;
        m_ack = 0;
        case (m_state)
            0: nxt = 1;
            1: if (age == C_SIM_HOLD) nxt = 2;
            2: if (ltp == 5'h0F) nxt = 3;
               else if (age == C_LT) begin nxt = 0; tmo = 1; end
            3: if (age == C_APP_DELAY - 1) nxt = 4;
            4: if (rec_req[e % 8]) begin nxt = 0; m_ack = 1; end
            default: nxt = 0;
        endcase
        if (evp != 0) begin nxt = 0; tmo = 0; end
        if (tmo != 0) m_to = 1;
        if (nxt == 0 && m_cnt < 255) m_cnt++;
        if (nxt != m_state || nxt == 0) m_since = e;
        m_state = nxt;
    endtask

    // Compare process: DUT against model on every cycle.
    initial forever begin
        @(negedge clk);
        if (ecnt <= 2) begin
            m_state = 0; m_since = 2; m_cnt = 0; m_to = 0; m_ack = 0;
        end else begin
            model_step(ecnt);
        end
        check("srst",     srst,      (m_state <= 1) ? 1 : 0);
        check("crst",     crst,      (m_state <= 1) ? 1 : 0);
        check("app_rstn", app_rstn,  (m_state == 4) ? 1 : 0);
        check("seq",      seq_state, m_state);
        check("ack",      ack,       m_ack);
        check("count",    rst_count, m_cnt);
        check("timeout",  link_to,   m_to);
        if (ack === 1'b1) begin ack_flag = 1; ack_edge = ecnt; ack_total++; end
        if (seq_state == 3'd4 && prev_seq != 4) run_entry = ecnt;
        prev_seq = seq_state;
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_edge(input int n);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (ecnt < n && guard < 100000);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int bound, input string name);
        int n = 0;
        while (seq_state !== s && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, seq_state, s);
    endtask

    task automatic pulse(input int which);
        tick;
        case (which)
            0: dlup = 1'b0;
            1: hotrst = 1'b0;
            default: l2 = 1'b0;
        endcase
        tick;
        dlup = 1'b1; hotrst = 1'b1; l2 = 1'b1;
    endtask

    task automatic do_req(input int bound, output int req_edge, output int got_edge);
        int n = 0;
        tick;
        req = 1'b1;
        ack_flag = 0;
        req_edge = ecnt + 1;
        while (!ack_flag && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("req_ack_seen", ack_flag, 1);
        got_edge = ack_edge;
        tick;
        req = 1'b0;
    endtask

    initial begin
        int k, w, n, re, ae, acks0;
        npor = 1'b0; test_sim = 1'b1; dlup = 1'b1; hotrst = 1'b1; l2 = 1'b1;
        ltssm = 5'h0F; req = 1'b0;
        repeat (3) @(posedge clk);
        #2 npor = 1'b1;

        // Power-on sequence
        wait_edge(34);
        check("po_srst_e34", srst, 1);
        check("po_model_e34", m_state, 1);
        wait_edge(35);
        check("po_srst_e35", srst, 0);
        check("po_crst_e35", crst, 0);
        check("po_model_e35", m_state, 2);
        wait_edge(50);
        check("po_app_e50", app_rstn, 0);
        wait_edge(51);
        check("po_app_e51", app_rstn, 1);
        check("po_seq_e51", seq_state, 4);
        check("po_cnt_e51", rst_count, 0);
        check("po_model_e51", m_state, 4);

        // Hot-reset exit pulse in RUN
        acks0 = ack_total;
        pulse(1);
        k = ecnt;
        wait_edge(k + 1);
        check("hot_srst_k1", srst, 0);
        wait_edge(k + 2);
        check("hot_srst_k2", srst, 1);
        check("hot_app_k2", app_rstn, 0);
        wait_state(3'd4, 200, "hot_run");
        check("hot_cnt", rst_count, 1);
        check("hot_noack", ack_total - acks0, 0);

        // Software request in RUN, then request raised during HOLD
        do_req(20, re, ae);
        check("sw_ack_edge", ae, re);
        pulse(1);
        wait_state(3'd1, 20, "sw_hold");
        do_req(300, re, ae);
        check("sw_pend_ack_edge", ae, run_entry + 1);
        wait_state(3'd4, 200, "sw_run");

        // Link timeout
        tick; ltssm = 5'h02;
        pulse(1);
        wait_state(3'd2, 200, "to_wait");
        w = ecnt;
        n = 0;
        while (link_to !== 1'b1 && n < 300) begin @(negedge clk); #1; n++; end
        check("to_edge", ecnt, w + C_LT);
        check("to_seq", seq_state, 0);
        tick; ltssm = 5'h0F;
        wait_state(3'd4, 300, "to_run");
        check("to_sticky", link_to, 1);

        // Disabled during APP_DLY, then dlup pulse mid-HOLD
        pulse(0);
        wait_state(3'd3, 200, "dis_app");
        tick; ltssm = 5'h10;
        k = ecnt + 1;
        tick; ltssm = 5'h0F;
        wait_edge(k + 2);
        check("dis_seq", seq_state, 0);
        check("dis_app_rstn", app_rstn, 0);
        wait_state(3'd1, 20, "hold_enter");
        repeat (10) tick;
        pulse(0);
        k = ecnt;
        wait_state(3'd2, 200, "hold_restart");
        check("hold_restart_edge", ecnt, k + 2 + 1 + C_SIM_HOLD);
        wait_state(3'd4, 200, "hold_run");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tick;
            dlup = 1'b1; hotrst = 1'b1; l2 = 1'b1;
            if ($urandom_range(0, 99) < 2) begin
                case ($urandom_range(0, 2))
                    0: dlup = 1'b0;
                    1: hotrst = 1'b0;
                    default: l2 = 1'b0;
                endcase
            end
            if ($urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1: ltssm = 5'h02;
                    2: ltssm = 5'h10;
                    3: ltssm = 5'(($urandom_range(0, 14)));
                    default: ltssm = 5'h0F;
                endcase
            end
            if (req && ack_flag) req = 1'b0;
            else if (!req && $urandom_range(0, 149) == 0) begin
                ack_flag = 0;
                req = 1'b1;
            end
        end
        tick;
        dlup = 1'b1; hotrst = 1'b1; l2 = 1'b1; ltssm = 5'h0F;
        n = 0;
        while (req && !ack_flag && n < 500) begin tick; n++; end
        check("rand_req_done", ack_flag | !req, 1);
        tick; req = 1'b0;
        wait_state(3'd4, 300, "rand_run");

        // Asynchronous power-on reset in WAIT_LINK
        tick; ltssm = 5'h02;
        pulse(2);
        wait_state(3'd2, 200, "por_wait");
        repeat (5) tick;
        @(posedge clk);
        #3 npor = 1'b0;
        #1;
        check("por_srst", srst, 1);
        check("por_crst", crst, 1);
        check("por_app", app_rstn, 0);
        check("por_ack", ack, 0);
        check("por_seq", seq_state, 0);
        check("por_cnt", rst_count, 0);
        check("por_to", link_to, 0);
        ltssm = 5'h0F;
        repeat (3) tick;
        npor = 1'b1;
        wait_state(3'd4, 200, "por_run");
        check("por_run_cnt", rst_count, 0);
        check("por_run_to", link_to, 0);

        // Back-to-back events saturate the counter
        tick; l2 = 1'b0;
        repeat (300) tick;
        l2 = 1'b1;
        wait_state(3'd4, 200, "sat_run");
        check("sat_cnt", rst_count, 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
